// File: rtl/freq_synth_pkg.sv
// Shared types and constants for the programmable square-wave generator.
package freq_synth_pkg;

    localparam int BCD_DIGITS = 6;
    localparam int ACC_W      = 20;
    localparam int DIG_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DIV   = 3'd3,
        ST_LOAD  = 3'd4,
        ST_RUN   = 3'd5
    } state_e;

    function automatic logic is_busy_state(input state_e s);
        return (s == ST_CONV) || (s == ST_CHECK) || (s == ST_DIV) || (s == ST_LOAD);
    endfunction

endpackage

// File: rtl/freq_synth_controller_div.sv
// Iterative restoring divider: W quotient bits MSB first, the first bit on the start cycle.
module half_period_div #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done_tick
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    // quo doubles as the dividend shift register; quotient bits enter at the LSB
    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                                input logic [W-1:0] quo,
                                                input logic [W-1:0] dvs);
        logic [W:0] trial;
        logic       q_bit;
        trial = {rem, quo[W-1]};
        if (trial >= {1'b0, dvs}) begin
            trial = trial - {1'b0, dvs};
            q_bit = 1'b1;
        end else begin
            q_bit = 1'b0;
        end
        return {trial[W-1:0], quo[W-2:0], q_bit};
    endfunction

    // Next-state for remainder, quotient shifter and bit counter
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            {rem_d, quo_d} = div_step({W{1'b0}}, dividend, divisor);
            dvs_d          = divisor;
            cnt_d          = CW'(W - 1);
        end else if (cnt_q != {CW{1'b0}}) begin
            {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
            cnt_d          = cnt_q - CW'(1);
            done_d         = (cnt_q == CW'(1));
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= {W{1'b0}};
            quo_q  <= {W{1'b0}};
            dvs_q  <= {W{1'b0}};
            cnt_q  <= {CW{1'b0}};
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quotient  = quo_q;
    assign done_tick = done_q;

endmodule

// File: rtl/freq_synth_controller.sv
// BCD-programmed square-wave generator: BCD->binary, range check, CLK_HZ/(2*freq) divide,
// then a half-period toggle counter; a retune keeps the old wave alive until the new load.
module freq_synth_controller
    import freq_synth_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int W      = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic [3:0] dig4,
    input  logic [3:0] dig5,
    output logic       wave_out,
    output logic       busy,
    output logic       running,
    output logic       done_tick,
    output logic       err
);

    localparam int             SR_W      = BCD_DIGITS * DIG_W;
    localparam logic [W-1:0]   NUMERATOR = W'(CLK_HZ);
    localparam logic [31:0]    MAX_FREQ  = 32'(CLK_HZ / 2);
    localparam logic [2:0]     LAST_DIG  = 3'(BCD_DIGITS - 1);

    state_e            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [2:0]        conv_cnt_q, conv_cnt_d;
    logic              bad_q, bad_d;
    logic              retune_q, retune_d;
    logic [W-1:0]      half_q, half_d;
    logic [W-1:0]      cnt_q, cnt_d;
    logic              wave_q, wave_d;
    logic              busy_q, busy_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              start_acc_s;
    logic              conv_last_s;
    logic              reject_s;
    logic              div_start_s;
    logic              div_done_s;
    logic [W-1:0]      div_quot_s;
    logic [W-1:0]      div_divisor_s;
    logic [DIG_W-1:0]  head_s;

    assign start_acc_s   = start & ~stop & ((state_q == ST_IDLE) | (state_q == ST_RUN));
    assign conv_last_s   = (conv_cnt_q == LAST_DIG);
    assign head_s        = sr_q[SR_W-1 -: DIG_W];
    assign reject_s      = bad_q | (acc_q == {ACC_W{1'b0}}) | (32'(acc_q) > MAX_FREQ);
    assign div_start_s   = (state_q == ST_CHECK) & ~reject_s & ~stop;
    assign div_divisor_s = W'({acc_q, 1'b0});

    half_period_div #(.W(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .dividend  (NUMERATOR),
        .divisor   (div_divisor_s),
        .quotient  (div_quot_s),
        .done_tick (div_done_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; stop overrides everything
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_acc_s) state_d = ST_CONV;  else state_d = ST_IDLE;
                ST_CONV:  if (conv_last_s) state_d = ST_CHECK; else state_d = ST_CONV;
                ST_CHECK: if (reject_s)    state_d = ST_IDLE;  else state_d = ST_DIV;
                ST_DIV:   if (div_done_s)  state_d = ST_LOAD;  else state_d = ST_DIV;
                ST_LOAD:  state_d = ST_RUN;
                ST_RUN:   if (start_acc_s) state_d = ST_CONV;  else state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs, computed from the upcoming state so the flops line up with it
    always_comb begin
        busy_d    = is_busy_state(state_d);
        running_d = (state_d == ST_RUN) | (retune_d & busy_d);
        done_d    = (state_q == ST_LOAD) & ~stop;
        if (start_acc_s) begin
            err_d = 1'b0;
        end else if ((state_q == ST_CHECK) & reject_s & ~stop) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // BCD accumulation and retune bookkeeping
    always_comb begin
        sr_d       = sr_q;
        acc_d      = acc_q;
        conv_cnt_d = conv_cnt_q;
        bad_d      = bad_q;
        if (start_acc_s) begin
            sr_d       = {dig5, dig4, dig3, dig2, dig1, dig0};
            acc_d      = {ACC_W{1'b0}};
            conv_cnt_d = 3'd0;
            bad_d      = 1'b0;
        end else if (state_q == ST_CONV) begin
            acc_d      = acc_q * ACC_W'(10) + ACC_W'(head_s);
            bad_d      = bad_q | (head_s > 4'd9);
            sr_d       = {sr_q[SR_W-DIG_W-1:0], {DIG_W{1'b0}}};
            conv_cnt_d = conv_cnt_q + 3'd1;
        end else begin
            acc_d = acc_q;
        end

        if (stop) begin
            retune_d = 1'b0;
        end else if (start_acc_s) begin
            retune_d = (state_q == ST_RUN);
        end else if ((state_q == ST_LOAD) | ((state_q == ST_CHECK) & reject_s)) begin
            retune_d = 1'b0;
        end else begin
            retune_d = retune_q;
        end
    end

    // Half-period toggle counter; the old wave keeps going through a retune
    always_comb begin
        half_d = half_q;
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (stop) begin
            wave_d = 1'b0;
            cnt_d  = {W{1'b0}};
        end else if (state_q == ST_LOAD) begin
            half_d = div_quot_s;
            cnt_d  = {W{1'b0}};
            wave_d = 1'b1;
        end else if ((state_q == ST_CHECK) & reject_s) begin
            wave_d = 1'b0;
            cnt_d  = {W{1'b0}};
        end else if ((state_q == ST_RUN) | retune_q) begin
            if (cnt_q == half_q - W'(1)) begin
                wave_d = ~wave_q;
                cnt_d  = {W{1'b0}};
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else begin
            wave_d = wave_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q       <= {SR_W{1'b0}};
            acc_q      <= {ACC_W{1'b0}};
            conv_cnt_q <= 3'd0;
            bad_q      <= 1'b0;
            retune_q   <= 1'b0;
            half_q     <= {W{1'b0}};
            cnt_q      <= {W{1'b0}};
            wave_q     <= 1'b0;
            busy_q     <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            acc_q      <= acc_d;
            conv_cnt_q <= conv_cnt_d;
            bad_q      <= bad_d;
            retune_q   <= retune_d;
            half_q     <= half_d;
            cnt_q      <= cnt_d;
            wave_q     <= wave_d;
            busy_q     <= busy_d;
            running_q  <= running_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign wave_out  = wave_q;
    assign busy      = busy_q;
    assign running   = running_q;
    assign done_tick = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_freq_synth_controller.sv
// Directed bench: dut a runs at CLK_HZ=100/W=8, dut b at the 50 MHz/W=26 defaults.
module tb_freq_synth_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_start, a_stop, b_start, b_stop;
    logic [3:0] a_dig0, a_dig1, a_dig2, a_dig3, a_dig4, a_dig5;
    logic [3:0] b_dig0, b_dig1, b_dig2, b_dig3, b_dig4, b_dig5;
    logic       a_wave, a_busy, a_running, a_done, a_err;
    logic       b_wave, b_busy, b_running, b_done, b_err;

    int n_checks = 0;
    int n_fail   = 0;

    freq_synth_controller #(.CLK_HZ(100), .W(8)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .stop(a_stop),
        .dig0(a_dig0), .dig1(a_dig1), .dig2(a_dig2), .dig3(a_dig3), .dig4(a_dig4), .dig5(a_dig5),
        .wave_out(a_wave), .busy(a_busy), .running(a_running), .done_tick(a_done), .err(a_err)
    );

    freq_synth_controller dut_b (
        .clk(clk), .rst(rst), .start(b_start), .stop(b_stop),
        .dig0(b_dig0), .dig1(b_dig1), .dig2(b_dig2), .dig3(b_dig3), .dig4(b_dig4), .dig5(b_dig5),
        .wave_out(b_wave), .busy(b_busy), .running(b_running), .done_tick(b_done), .err(b_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {wave, busy, running, done, err}
    function automatic logic [4:0] outs(input int which);
        if (which == 0) return {a_wave, a_busy, a_running, a_done, a_err};
        else            return {b_wave, b_busy, b_running, b_done, b_err};
    endfunction

    task automatic go(input int which, input logic [23:0] d);
        if (which == 0) begin
            {a_dig5, a_dig4, a_dig3, a_dig2, a_dig1, a_dig0} = d;
            a_start = 1'b1;
        end else begin
            {b_dig5, b_dig4, b_dig3, b_dig2, b_dig1, b_dig0} = d;
            b_start = 1'b1;
        end
        tick();
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic pulse_stop();
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
    endtask

    task automatic wait_done(input int which, input int max, output int n);
        logic [4:0] o;
        n = 0;
        do begin
            tick();
            n++;
            o = outs(which);
        end while (!o[1] && n < max);
    endtask

    task automatic wave_check(input int which, input string tag, input int half, input int off,
                              input int nsamp);
        logic [63:0] obs, exp;
        logic [4:0]  o;
        obs = 64'd0;
        exp = 64'd0;
        for (int i = 0; i < nsamp; i++) begin
            o      = outs(which);
            obs[i] = o[4];
            exp[i] = (((i + off) / half) % 2) == 0;
            if (i < nsamp - 1) tick();
        end
        check_eq(tag, obs, exp);
    endtask

    task automatic count_done(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (a_done) hits++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached without $finish");
        $fatal(1);
    end

    initial begin
        int n;
        int hits;
        logic [23:0] rej_vec [3];
        logic [63:0] obs, exp;
        logic        done_seen;

        rej_vec[0] = 24'h000000;
        rej_vec[1] = 24'h000051;
        rej_vec[2] = 24'h000A00;

        rst = 1'b1;
        a_start = 1'b0; a_stop = 1'b0; b_start = 1'b0; b_stop = 1'b0;
        {a_dig5, a_dig4, a_dig3, a_dig2, a_dig1, a_dig0} = 24'h000000;
        {b_dig5, b_dig4, b_dig3, b_dig2, b_dig1, b_dig0} = 24'h000000;
        repeat (3) tick();
        check_eq("reset_a", outs(0), 5'b00000);
        check_eq("reset_b", outs(1), 5'b00000);
        rst = 1'b0;
        tick();

        // 10 Hz: half = 5
        go(0, 24'h000010);
        check_eq("f10_busy_run", {a_busy, a_running}, 2'b10);
        wait_done(0, 40, n);
        check_eq("f10_latency", n, 16);
        check_eq("f10_at_load", outs(0), 5'b10110);
        tick();
        check_eq("f10_done_1cyc", a_done, 1'b0);
        wave_check(0, "f10_wave", 5, 1, 30);
        pulse_stop();
        check_eq("stop_idle", outs(0), 5'b00000);

        // 50 Hz: half = 1
        go(0, 24'h000050);
        wait_done(0, 40, n);
        check_eq("f50_latency", n, 16);
        wave_check(0, "f50_wave", 1, 0, 10);
        pulse_stop();

        // 3 Hz: half = 100/6 truncated = 16
        go(0, 24'h000003);
        wait_done(0, 40, n);
        check_eq("f3_latency", n, 16);
        wave_check(0, "f3_wave", 16, 0, 40);
        pulse_stop();

        // Rejected requests: zero, above CLK_HZ/2, non-BCD digit
        for (int v = 0; v < 3; v++) begin
            go(0, rej_vec[v]);
            repeat (6) tick();
            check_eq($sformatf("rej%0d_err_t6", v), a_err, 1'b0);
            tick();
            check_eq($sformatf("rej%0d_t7", v), outs(0), 5'b00001);
            count_done(20, hits);
            check_eq($sformatf("rej%0d_no_done", v), hits, 0);
        end
        pulse_stop();
        check_eq("stop_keeps_err", a_err, 1'b1);

        // Retune 10 Hz -> 25 Hz; start from IDLE clears err
        go(0, 24'h000010);
        check_eq("err_cleared", a_err, 1'b0);
        wait_done(0, 40, n);
        check_eq("rt_first_latency", n, 16);
        repeat (3) tick();
        go(0, 24'h000025);
        check_eq("rt_busy_run", {a_busy, a_running, a_err}, 3'b110);
        obs = 64'd0;
        exp = 64'd0;
        done_seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            obs[k] = a_wave;
            exp[k] = (((4 + k) / 5) % 2) == 0;
            done_seen = done_seen | a_done;
            tick();
        end
        check_eq("rt_old_wave", obs, exp);
        check_eq("rt_no_early_done", done_seen, 1'b0);
        check_eq("rt_done", {a_done, a_err}, 2'b10);
        wave_check(0, "rt_new_wave", 2, 0, 12);

        // stop during DIV
        pulse_stop();
        go(0, 24'h000010);
        repeat (9) tick();
        check_eq("div_busy", a_busy, 1'b1);
        pulse_stop();
        check_eq("div_stop", outs(0), 5'b00000);
        count_done(20, hits);
        check_eq("div_stop_no_done", hits, 0);

        // start and stop together: stop wins
        {a_dig5, a_dig4, a_dig3, a_dig2, a_dig1, a_dig0} = 24'h000010;
        a_start = 1'b1;
        a_stop  = 1'b1;
        tick();
        a_start = 1'b0;
        a_stop  = 1'b0;
        check_eq("start_stop", outs(0), 5'b00000);
        count_done(20, hits);
        check_eq("start_stop_no_done", {hits[7:0], a_busy}, 9'd0);

        // Defaults: 999999 Hz -> half = 25
        go(1, 24'h999999);
        wait_done(1, 60, n);
        check_eq("def_latency", n, 34);
        wave_check(1, "def_wave", 25, 0, 60);
        check_eq("def_running", b_running, 1'b1);
        rst = 1'b1;
        tick();
        check_eq("rst_in_run_b", outs(1), 5'b00000);
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
